// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared dsp datapath constants, divider command codes and state type
package dsp_pkg;

  localparam int DSP_WIDTH = 32;

  localparam logic [1:0] CMD_DIVU = 2'd0;
  localparam logic [1:0] CMD_DIV  = 2'd1;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/dsp_div_if.sv
// rtl/dsp_div_if.sv - request/response handshake bundle for the iterative divider
interface dsp_div_if
  import dsp_pkg::*;
#(
  parameter int WIDTH = DSP_WIDTH
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_command;
  logic [WIDTH-1:0]   req_in_1;
  logic [WIDTH-1:0]   req_in_2;
  logic               resp_valid;
  logic               resp_ready;
  logic [2*WIDTH-1:0] resp_result;

  modport master (
    output req_valid, req_command, req_in_1, req_in_2, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_command, req_in_1, req_in_2, resp_ready,
    output req_ready, resp_valid, resp_result
  );
endinterface

// File: rtl/dsp_div_step.sv
// rtl/dsp_div_step.sv - one combinational restoring-division iteration
module dsp_div_step
  import dsp_pkg::*;
#(
  parameter int WIDTH = DSP_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Extra top bit makes the borrow of the trial subtract visible as a sign.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {2'b00, divisor};
    if (diff[WIDTH+1]) begin
      rem_next = shifted[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = diff[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/dsp_div.sv
// rtl/dsp_div.sv - iterative radix-2 restoring divider, signed/unsigned, fixed latency
module dsp_div
  import dsp_pkg::*;
#(
  parameter int WIDTH = DSP_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic     clk,
  input  logic     reset,
  dsp_div_if.slave bus
);

  div_state_t state, state_next;

  logic [WIDTH-1:0]   a_raw, b_raw;
  logic [1:0]         cmd;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [CNT_W-1:0]   cnt;
  logic               neg_q, neg_r, div0;
  logic [2*WIDTH-1:0] result;

  logic               is_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH-1:0]   fix_q, fix_r;

  dsp_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.req_valid)      state_next = PREP;
      PREP:                         state_next = ITER;
      ITER: if (cnt == '0)          state_next = FIX;
      FIX:                          state_next = DONE;
      DONE: if (bus.resp_ready)     state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  assign bus.req_ready   = (state == IDLE) && reset;
  assign bus.resp_valid  = (state == DONE);
  assign bus.resp_result = result;

  // Reserved command codes fall through to unsigned. The magnitude of
  // min_int wraps to itself, which is exactly 2**(WIDTH-1) read unsigned.
  always_comb begin
    is_signed = (cmd == CMD_DIV);
    mag_a     = (is_signed && a_raw[WIDTH-1]) ? -a_raw : a_raw;
    mag_b     = (is_signed && b_raw[WIDTH-1]) ? -b_raw : b_raw;
    fix_q     = neg_q ? -quo : quo;
    fix_r     = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    if (div0) begin
      fix_q = '1;
      fix_r = a_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_raw   <= '0;
      b_raw   <= '0;
      cmd     <= CMD_DIVU;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
      result  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            a_raw <= bus.req_in_1;
            b_raw <= bus.req_in_2;
            cmd   <= bus.req_command;
          end
        end
        PREP: begin
          quo     <= mag_a;
          divisor <= mag_b;
          rem     <= '0;
          cnt     <= CNT_W'(WIDTH - 1);
          neg_q   <= is_signed && (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
          neg_r   <= is_signed && a_raw[WIDTH-1];
          div0    <= (b_raw == '0);
        end
        ITER: begin
          rem <= step_rem;
          quo <= step_quo;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX:     result <= {fix_r, fix_q};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_div.sv
// tb/tb_dsp_div.sv - table-driven and scoreboard bench for dsp_div
module tb_dsp_div;
  import dsp_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  typedef struct {
    logic [1:0]    cmd;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2*W-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dsp_div_if #(.WIDTH(W)) bus ();

  dsp_div #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] sb[$];
  vec_t vecs[12];

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present a request from a negedge, wait for acceptance, then scramble the inputs.
  task automatic send(input logic [1:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] exp);
    int n;
    @(negedge clk);
    bus.req_command = cmd;
    bus.req_in_1    = a;
    bus.req_in_2    = b;
    bus.req_valid   = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1");
    end
    @(posedge clk);
    sb.push_back(exp);
    @(negedge clk);
    bus.req_valid   = 1'b0;
    bus.req_command = 2'($urandom);
    bus.req_in_1    = $urandom;
    bus.req_in_2    = $urandom;
  endtask

  // Called on the negedge after the accept edge; returns on the negedge resp_valid is seen.
  task automatic wait_valid(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.resp_valid && k < 200);
    chk({nm, "_latency"}, 64'(k), 64'(LAT));
  endtask

  task automatic pop_cmp(input string nm);
    logic [2*W-1:0] e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got response expected empty scoreboard", nm);
    end else begin
      e = sb.pop_front();
      chk(nm, bus.resp_result, e);
    end
  endtask

  task automatic run_op(input string nm, input vec_t v);
    send(v.cmd, v.a, v.b, v.exp);
    wait_valid(nm);
    pop_cmp(nm);
    @(negedge clk);
    chk({nm, "_ready_back"}, 64'({bus.req_ready, bus.resp_valid}), 64'(2'b10));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2*W-1:0] held;
    vecs[0]  = '{CMD_DIVU, 32'd100,        32'd7,          64'h00000002_0000000E};
    vecs[1]  = '{CMD_DIV,  32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD};
    vecs[2]  = '{CMD_DIV,  32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD};
    vecs[3]  = '{CMD_DIVU, 32'h00001234,   32'h00000000,   64'h00001234_FFFFFFFF};
    vecs[4]  = '{CMD_DIV,  32'hFFFFFFF0,   32'h00000000,   64'hFFFFFFF0_FFFFFFFF};
    vecs[5]  = '{CMD_DIV,  32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000};
    vecs[6]  = '{CMD_DIVU, 32'hFFFFFFFF,   32'h00000001,   64'h00000000_FFFFFFFF};
    vecs[7]  = '{CMD_DIVU, 32'hFFFFFFF9,   32'h00000002,   64'h00000001_7FFFFFFC};
    vecs[8]  = '{2'd2,     32'hFFFFFFF9,   32'h00000002,   64'h00000001_7FFFFFFC};
    vecs[9]  = '{CMD_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E};
    vecs[10] = '{CMD_DIVU, 32'd5,          32'd9,          64'h00000005_00000000};
    vecs[11] = '{CMD_DIV,  32'h80000000,   32'h00000002,   64'h00000000_C0000000};

    bus.req_valid   = 1'b0;
    bus.req_command = CMD_DIVU;
    bus.req_in_1    = '0;
    bus.req_in_2    = '0;
    bus.resp_ready  = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(bus.req_ready), 64'(0));
    chk("reset_valid", 64'(bus.resp_valid), 64'(0));
    reset = 1'b1;
    #1;
    chk("release_ready", 64'(bus.req_ready), 64'(1));
    chk("release_result", bus.resp_result, '0);

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure with a competing request held during DONE.
    bus.resp_ready = 1'b0;
    send(CMD_DIVU, 32'd1000, 32'd10, 64'h00000000_00000064);
    wait_valid("bp");
    held = bus.resp_result;
    chk("bp_first", held, 64'h00000000_00000064);
    bus.req_command = CMD_DIVU;
    bus.req_in_1    = 32'd50;
    bus.req_in_2    = 32'd5;
    bus.req_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i),
          {bus.resp_result[2*W-3:0], bus.resp_valid, bus.req_ready},
          {held[2*W-3:0], 1'b1, 1'b0});
    end
    bus.resp_ready = 1'b1;
    chk("bp_hs_ready", 64'(bus.req_ready), 64'(0));
    pop_cmp("bp_result");
    @(negedge clk);
    chk("bp_idle", 64'({bus.req_ready, bus.resp_valid}), 64'(2'b10));
    @(posedge clk);
    sb.push_back(64'h00000000_0000000A);
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_valid("b2b");
    pop_cmp("b2b_result");
    @(negedge clk);

    // Reset during ITER aborts the operation with no response.
    send(CMD_DIVU, 32'd100, 32'd7, 64'h00000002_0000000E);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_state", {bus.resp_result[2*W-2:0], bus.resp_valid}, '0);
    sb.delete();
    reset = 1'b1;
    #1;
    chk("abort_ready", 64'(bus.req_ready), 64'(1));
    run_op("after_abort", '{CMD_DIVU, 32'd9, 32'd3, 64'h00000000_00000003});
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
